// File: rtl/fetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture into a small
// prefetch FIFO, and {pc, instr, valid} presentation to decode with stall and redirect handling.
module fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           ILEN       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [ILEN-1:0]       imem_rsp_data_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ILEN-1:0]       instr_o,
    output logic                  instr_valid_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_discard;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [ILEN-1:0]       r_fifo_instr [FIFO_DEPTH];

    logic [CW:0]           w_inflight;
    logic                  w_credit;
    logic                  w_req_fire;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit   = w_inflight < (CW + 1)'(FIFO_DEPTH);
    assign w_target   = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // r_run keeps the request channel quiet while in reset and for the first cycle after release.
    assign imem_req_valid_o = r_run && !redirect_i && w_credit;
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;

    assign w_empty       = (r_count == '0);
    assign instr_valid_o = !w_empty && !redirect_i;
    assign w_pop         = instr_valid_o && !stall_i;
    assign w_push        = imem_rsp_valid_i && !redirect_i && (r_discard == '0);

    assign pc_o    = w_empty ? r_rsp_pc : r_fifo_pc[r_rd_ptr];
    assign instr_o = w_empty ? NOP_INSTR : r_fifo_instr[r_rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_run         <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (redirect_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc    <= w_target;
                r_rsp_pc      <= w_target;
                r_outstanding <= r_outstanding - CW'(imem_rsp_valid_i);
                r_discard     <= r_outstanding - CW'(imem_rsp_valid_i);
                r_count       <= '0;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
            end else begin
                r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid_i);
                r_count       <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                end
                if (imem_rsp_valid_i && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                    r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(4);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
            r_fifo_instr[r_wr_ptr] <= imem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed table after reset, hand sequences for stall/redirect/wrap/async reset,
// and a randomized run against a queue-based memory and delivery model.
module tb_fetch;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;

    fetch #(
        .ADDR_WIDTH (32),
        .ILEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .pc_o             (pc_o),
        .instr_o          (instr_o),
        .instr_valid_o    (instr_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic        stale;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       memq[$];
    ent_t        mq[$];
    logic [31:0] m_fetch;
    logic        started;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          delivered = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic        c_fire, c_pop, c_rsp, c_rdr;
    logic [31:0] c_rpc;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req_valid"}, imem_req_valid_o, 1'b0);
        check1({tag, "_instr_valid"}, instr_valid_o, 1'b0);
        check({tag, "_pc"}, pc_o, RST_PC);
        check({tag, "_instr"}, instr_o, NOP);
    endtask

    task automatic clear_model();
        memq.delete();
        mq.delete();
        m_fetch = RST_PC;
        started = 1'b0;
        imem_rsp_valid_i = 1'b0;
        redirect_i = 1'b0;
        stall_i = 1'b0;
    endtask

    // Called at a negedge: drive inputs, then compare outputs against the model.
    task automatic apply(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
        logic exp_rv, exp_iv;
        imem_req_ready_i = rdy;
        stall_i          = stl;
        redirect_i       = rdr;
        redirect_pc_i    = rpc;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = memq[0].addr;
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
        #1;
        exp_rv = started && !rdr && (memq.size() + mq.size() < int'(DEPTH));
        check1("req_valid", imem_req_valid_o, exp_rv);
        if (imem_req_valid_o) check("req_addr", imem_req_addr_o, m_fetch);
        exp_iv = (mq.size() > 0) && !rdr;
        check1("instr_valid", instr_valid_o, exp_iv);
        if (mq.size() > 0) begin
            check("pc", pc_o, mq[0].pc);
            check("instr", instr_o, mq[0].instr);
        end else begin
            check("instr_empty", instr_o, NOP);
        end
        c_fire = imem_req_valid_o && rdy;
        c_pop  = exp_iv && !stl;
        c_rsp  = imem_rsp_valid_i;
        c_rdr  = rdr;
        c_rpc  = rpc;
    endtask

    task automatic advance();
        mreq_t e;
        int    due;
        @(posedge clk_i);
        if (c_rdr) begin
            mq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
        end else if (c_pop) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (c_rsp) begin
            e = memq.pop_front();
            if (!e.stale && !c_rdr) mq.push_back('{pc: e.addr, instr: e.addr});
        end
        if (c_fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: m_fetch, due: due, stale: c_rdr});
            m_fetch = m_fetch + 32'd4;
        end
        if (c_rdr) m_fetch = {c_rpc[31:2], 2'b00};
        started = 1'b1;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [31:0] rpc);
        apply(rdy, stl, rdr, rpc);
        advance();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_model();
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
    endtask

    task automatic wait_first_valid(input logic [31:0] exp, input string name);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'h0);
            if (instr_valid_o) begin
                check(name, pc_o, exp);
                found = 1;
            end
            advance();
        end
        if (!found) fail_now(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ready=1, 1-cycle memory; cycle 0 is the first cycle after reset release.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h08};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h10};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h10};

        lat_min = 1; lat_max = 1;
        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].ready, vecs[i].stall, 1'b0, 32'h0);
            check1("tbl_req_valid", imem_req_valid_o, vecs[i].exp_rv);
            check("tbl_req_addr", imem_req_addr_o, vecs[i].exp_addr);
            check1("tbl_instr_valid", instr_valid_o, vecs[i].exp_iv);
            check("tbl_pc", pc_o, vecs[i].exp_pc);
            advance();
        end

        // Stall right after 0x0 is consumed: 0x4 held, buffer fills, requests stop.
        do_reset();
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'h0);
            check("stall_pc_hold", pc_o, 32'h4);
            check1("stall_valid", instr_valid_o, 1'b1);
            if (i == 4) check1("stall_no_req", imem_req_valid_o, 1'b0);
            advance();
        end
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("release_pc0", pc_o, 32'h4);
        advance();
        apply(1'b1, 1'b0, 1'b0, 32'h0);
        check("release_pc1", pc_o, 32'h8);
        advance();

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        apply(1'b1, 1'b0, 1'b1, 32'h100);
        check1("redir_no_req", imem_req_valid_o, 1'b0);
        advance();
        wait_first_valid(32'h100, "redir_first_pc");
        step(1'b1, 1'b0, 1'b1, 32'h102);
        wait_first_valid(32'h100, "redir_align");

        // Back-to-back redirects while stalled with responses in flight.
        lat_min = 2; lat_max = 2;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 1'b1, 32'h300);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
        wait_first_valid(32'h300, "b2b_redir_pc");

        // Address wrap.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        wait_first_valid(32'hFFFF_FFF8, "wrap_pc0");
        wait_first_valid(32'hFFFF_FFFC, "wrap_pc1");
        wait_first_valid(32'h0000_0000, "wrap_pc2");
        wait_first_valid(32'h0000_0004, "wrap_pc3");

        // Randomized ready, latency, stall and occasional redirects.
        lat_min = 1; lat_max = 3;
        delivered = 0;
        for (int i = 0; i < 30000 && delivered < 1000; i++) begin
            logic        rdy, stl, rdr;
            logic [31:0] rpc;
            rdy = ($urandom_range(3, 0) != 0);
            stl = ($urandom_range(4, 0) == 0);
            rdr = ($urandom_range(59, 0) == 0);
            rpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : $urandom;
            step(rdy, stl, rdr, rpc);
        end
        if (delivered < 1000) fail_now("random_delivered");

        // Asynchronous reset mid-burst, away from any clock edge.
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_ni = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_first_valid(RST_PC, "after_rst_pc");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
